// File: rtl/axis_tb_pkg.sv
// Shared constants and helpers for the token-bucket rate limiter.
//   RATE_FRAC_BITS : fractional bits of cfg_rate and of the bucket (Q.8)
//   KEEP_MAX       : widest tkeep the popcount helper accepts
//   bucket_bits()  : signed bucket width for a given integer burst width
//   popcount()     : number of set bits in a (zero-extended) tkeep
package axis_tb_pkg;

  localparam int unsigned RATE_FRAC_BITS = 8;
  localparam int unsigned KEEP_MAX       = 64;

  // Integer bits + fractional bits + sign bit.
  function automatic int unsigned bucket_bits(input int unsigned burst_width);
    return burst_width + RATE_FRAC_BITS + 1;
  endfunction

  function automatic int unsigned popcount(input logic [KEEP_MAX-1:0] keep);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered AXI4-Stream stage (output register + skid entry).
//   s_data/s_valid : upstream payload and valid
//   s_ready        : the registered ready the upstream currently sees
//   ready_early    : ready to be registered by the owner for the next cycle
//   m_data/m_valid/m_ready : downstream handshake, fully registered
module axis_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_ready,
  output logic             ready_early,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             temp_valid;
  logic [WIDTH-1:0] temp_data;
  logic             m_valid_next;
  logic             temp_valid_next;
  logic             store_out;
  logic             store_temp;
  logic             temp_to_out;

  // The owner may only lower ready relative to ready_early, which keeps the
  // invariant that the skid entry is empty whenever s_ready is high.
  assign ready_early = m_ready || (!temp_valid && (!m_valid || !s_valid));

  always_comb begin
    m_valid_next    = m_valid;
    temp_valid_next = temp_valid;
    store_out       = 1'b0;
    store_temp      = 1'b0;
    temp_to_out     = 1'b0;
    if (s_ready) begin
      if (m_ready || !m_valid) begin
        m_valid_next = s_valid;
        store_out    = 1'b1;
      end else begin
        temp_valid_next = s_valid;
        store_temp      = 1'b1;
      end
    end else if (m_ready) begin
      m_valid_next    = temp_valid;
      temp_valid_next = 1'b0;
      temp_to_out     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      temp_valid <= 1'b0;
    end else begin
      m_valid    <= m_valid_next;
      temp_valid <= temp_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (store_out) begin
      m_data <= s_data;
    end else if (temp_to_out) begin
      m_data <= temp_data;
    end
    if (store_temp) begin
      temp_data <= s_data;
    end
  end

endmodule

// File: rtl/axis_token_bucket_limit.sv
// AXI4-Stream rate limiter using a byte-granular Q.8 token bucket.
//   s_axis_* : input stream (tready registered, gated by the bucket)
//   m_axis_* : output stream, fully registered through axis_skid_reg
//   cfg_enable   : 0 = bypass, bucket pinned at cfg_burst
//   cfg_rate     : bytes added per cycle, 8 fractional bits
//   cfg_burst    : bucket ceiling in whole bytes
//   cfg_by_frame : only withhold tready between frames
//   stat_bucket  : bucket register (signed Q.8)
//   stat_paused  : registered gate term
module axis_token_bucket_limit
  import axis_tb_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = (DATA_WIDTH / 8),
  parameter int LAST_ENABLE  = 1,
  parameter int ID_ENABLE    = 0,
  parameter int ID_WIDTH     = 8,
  parameter int DEST_ENABLE  = 0,
  parameter int DEST_WIDTH   = 8,
  parameter int USER_ENABLE  = 1,
  parameter int USER_WIDTH   = 1,
  parameter int RATE_WIDTH   = 16,
  parameter int BUCKET_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    cfg_enable,
  input  logic [RATE_WIDTH-1:0]   cfg_rate,
  input  logic [BUCKET_WIDTH-1:0] cfg_burst,
  input  logic                    cfg_by_frame,
  output logic [BUCKET_WIDTH+8:0] stat_bucket,
  output logic                    stat_paused
);

  localparam int unsigned BW    = bucket_bits(BUCKET_WIDTH);
  // Headroom so that bucket + rate - cost can never wrap before clamping.
  localparam int unsigned EXT   = BW + RATE_WIDTH + 2;
  localparam int unsigned PAY_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  logic [KEEP_WIDTH-1:0] keep_eff;
  logic                  last_eff;
  logic [KEEP_MAX-1:0]   keep_wide;
  logic                  beat_accepted;
  logic                  out_ready_early;
  logic [PAY_W-1:0]      in_payload;
  logic [PAY_W-1:0]      out_payload;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DEST_WIDTH-1:0] out_dest;
  logic [USER_WIDTH-1:0] out_user;

  logic signed [BW-1:0]  bucket;
  logic signed [BW-1:0]  bucket_next;
  logic signed [EXT-1:0] bucket_ext;
  logic signed [EXT-1:0] rate_ext;
  logic signed [EXT-1:0] cost_ext;
  logic signed [EXT-1:0] ceil_ext;
  logic signed [EXT-1:0] floor_ext;
  logic signed [EXT-1:0] raw;
  logic                  frame_active;
  logic                  frame_active_next;
  logic                  pause_next;
  logic                  gate;

  assign keep_eff      = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign last_eff      = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
  assign beat_accepted = s_axis_tvalid && s_axis_tready;
  assign in_payload    = {s_axis_tdata, keep_eff, last_eff, s_axis_tid, s_axis_tdest, s_axis_tuser};

  axis_skid_reg #(.WIDTH(PAY_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .s_data      (in_payload),
    .s_valid     (s_axis_tvalid),
    .s_ready     (s_axis_tready),
    .ready_early (out_ready_early),
    .m_data      (out_payload),
    .m_valid     (m_axis_tvalid),
    .m_ready     (m_axis_tready)
  );

  assign {m_axis_tdata, out_keep, out_last, out_id, out_dest, out_user} = out_payload;
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? out_keep : '1;
  assign m_axis_tlast = (LAST_ENABLE != 0) ? out_last : 1'b1;
  assign m_axis_tid   = (ID_ENABLE != 0)   ? out_id   : '0;
  assign m_axis_tdest = (DEST_ENABLE != 0) ? out_dest : '0;
  assign m_axis_tuser = (USER_ENABLE != 0) ? out_user : '0;

  always_comb begin
    keep_wide = '0;
    keep_wide[KEEP_WIDTH-1:0] = keep_eff;
    bucket_ext = {{(EXT-BW){bucket[BW-1]}}, bucket};
    rate_ext   = {{(EXT-RATE_WIDTH){1'b0}}, cfg_rate};
    cost_ext   = beat_accepted ? (EXT'(popcount(keep_wide)) << RATE_FRAC_BITS) : '0;
    ceil_ext   = {{(EXT-BUCKET_WIDTH-RATE_FRAC_BITS){1'b0}}, cfg_burst, {RATE_FRAC_BITS{1'b0}}};
    floor_ext  = {{(EXT-BW+1){1'b1}}, {(BW-1){1'b0}}};
    raw        = bucket_ext + rate_ext - cost_ext;

    if (!cfg_enable) begin
      bucket_next = ceil_ext[BW-1:0];
    end else if (raw > ceil_ext) begin
      bucket_next = ceil_ext[BW-1:0];
    end else if (raw < floor_ext) begin
      bucket_next = floor_ext[BW-1:0];
    end else begin
      bucket_next = raw[BW-1:0];
    end

    frame_active_next = beat_accepted ? !last_eff : frame_active;
    pause_next        = cfg_enable && bucket_next[BW-1];
    // In frame mode a started frame is never cut; the deficit it builds is
    // paid back before the next frame may start.
    if (cfg_by_frame && (LAST_ENABLE != 0)) begin
      gate = pause_next && !frame_active_next;
    end else begin
      gate = pause_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bucket        <= '0;
      frame_active  <= 1'b0;
      s_axis_tready <= 1'b0;
      stat_paused   <= 1'b0;
    end else begin
      bucket        <= bucket_next;
      frame_active  <= frame_active_next;
      s_axis_tready <= out_ready_early && !gate;
      stat_paused   <= gate;
    end
  end

  assign stat_bucket = bucket;

endmodule
